// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-pipe SPU register file.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W      = 128;
    localparam int RF_DEPTH       = 128;
    localparam int RF_RD_PER_PIPE = 3;

    // Flat read-port index: k=0 ra, k=1 rb, k=2 rc.
    function automatic int rf_port_idx(input int pipe, input int k);
        return pipe * RF_RD_PER_PIPE + k;
    endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear sequencer: zeroes one row per cycle after reset or clear_req, then idles.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter  int DEPTH  = RF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, ptr_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
        end
    end

    // The pointer parks at DEPTH-1 on exit; a new clear always restarts it at 0.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
                else                               ptr_nxt   = clr_ptr + 1'b1;
            end
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign ready    = (state == IDLE);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// N-pipe register file: 1 write + 3 registered write-first reads per pipe,
// highest-pipe write priority with conflict flag, hardware clear sequencer.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter  int DATA_W    = RF_DATA_W,
    parameter  int DEPTH     = RF_DEPTH,
    parameter  int NUM_PIPES = 2,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int NUM_RD    = NUM_PIPES * RF_RD_PER_PIPE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    input  logic [NUM_PIPES-1:0]          wr_en,
    input  logic [NUM_PIPES*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_PIPES*DATA_W-1:0]   wr_data,
    input  logic                          clear_req,
    output logic                          ready,
    output logic                          wr_conflict
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              conflict;
    logic [NUM_RD*DATA_W-1:0] rd_next;

    rf_clear_fsm #(.DEPTH(DEPTH)) u_clear (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // A clear request in the same cycle drops any pipe write.
    assign wr_ok = ready & ~clear_req;

    // Ascending pipe loop: the last matching assignment (highest pipe) wins.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int p = 0; p < NUM_PIPES; p++)
                if (wr_en[p])
                    mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
    end

    for (genvar gp = 0; gp < NUM_PIPES; gp++) begin : g_pipe
        for (genvar gk = 0; gk < RF_RD_PER_PIPE; gk++) begin : g_rd
            localparam int R = rf_port_idx(gp, gk);
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] v;
            always_comb begin
                a = rd_addr[R*ADDR_W +: ADDR_W];
                v = mem[a];
                for (int p = 0; p < NUM_PIPES; p++)
                    if (wr_ok && wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == a)
                        v = wr_data[p*DATA_W +: DATA_W];
                if (!ready) v = '0;
                rd_next[R*DATA_W +: DATA_W] = v;
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++)
            for (int j = i + 1; j < NUM_PIPES; j++)
                if (wr_en[i] && wr_en[j] &&
                    wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
                    conflict = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            rd_data     <= rd_next;
            wr_conflict <= conflict & wr_ok;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expectations, a negedge monitor checks them.
module tb_reg_file_mp;

    localparam int DW = 128;
    localparam int DEPTH = 128;
    localparam int NP = 2;
    localparam int AW = 7;
    localparam int NR = NP * 3;
    localparam int K_RD = 0, K_RDY = 1, K_CONF = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NR*AW-1:0]   rd_addr = '0;
    logic [NR*DW-1:0]   rd_data;
    logic [NP-1:0]      wr_en = '0;
    logic [NP*AW-1:0]   wr_addr = '0;
    logic [NP*DW-1:0]   wr_data = '0;
    logic               clear_req = 1'b0;
    logic               ready;
    logic               wr_conflict;

    reg_file_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_PIPES(NP)) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .ready       (ready),
        .wr_conflict (wr_conflict)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            kind;
        int            port;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails  = 0;

    always @(negedge clock) begin : monitor
        exp_t e;
        logic [DW-1:0] act;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                K_RD:    act = rd_data[e.port*DW +: DW];
                K_RDY:   act = DW'(ready);
                default: act = DW'(wr_conflict);
            endcase
            checks++;
            if (e.due != cyc || act !== e.exp) begin
                fails++;
                $display("FAIL %s port=%0d due=%0d now=%0d actual=%h required=%h",
                         e.kind == K_RD ? "rd_data" : (e.kind == K_RDY ? "ready" : "wr_conflict"),
                         e.port, e.due, cyc, act, e.exp);
            end
        end
    end

    // All pushes refer to the value visible after the next rising edge.
    task automatic push(input int kind, input int port, input logic [DW-1:0] v);
        exp_t e;
        e.due = cyc + 1; e.kind = kind; e.port = port; e.exp = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int port, input int a);
        rd_addr[port*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic clear_to_ready();
        for (int i = 1; i <= DEPTH; i++) begin
            push(K_RDY, 0, DW'(i == DEPTH));
            step();
        end
    endtask

    logic [DW-1:0] pat_a5;
    int addrs[3] = '{0, 64, 127};

    initial begin
        pat_a5 = {16{8'hA5}};

        // reset values
        step(); step();
        for (int r = 0; r < NR; r++) push(K_RD, r, '0);
        push(K_RDY, 0, '0);
        push(K_CONF, 0, '0);
        step();
        reset = 1'b0;
        push(K_RD, 0, '0);
        clear_to_ready();

        // cleared contents on every port
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < NR; r++) begin
                set_rd(r, addrs[i]);
                push(K_RD, r, '0);
            end
            step();
        end
        for (int r = 0; r < NR; r++) set_rd(r, 0);

        // write then read
        set_wr(0, 5, pat_a5);
        step();
        wr_en = '0;
        set_rd(0, 5);
        push(K_RD, 0, pat_a5);
        step();

        // same-cycle bypass on pipe1 rc, then stored value
        set_wr(1, 9, DW'(32'h1234));
        set_rd(5, 9);
        push(K_RD, 5, DW'(32'h1234));
        push(K_CONF, 0, '0);
        step();
        wr_en = '0;
        push(K_RD, 5, DW'(32'h1234));
        step();

        // collision on r7: pipe1 wins, flag for exactly one cycle
        set_wr(0, 7, DW'(1));
        set_wr(1, 7, DW'(2));
        set_rd(2, 7);
        push(K_RD, 2, DW'(2));
        push(K_CONF, 0, DW'(1));
        step();
        wr_en = '0;
        set_rd(1, 7);
        push(K_RD, 1, DW'(2));
        push(K_CONF, 0, '0);
        step();

        // distinct addresses on both pipes: no conflict
        set_wr(0, 10, DW'(32'hAAAA));
        set_wr(1, 11, DW'(32'hBBBB));
        push(K_CONF, 0, '0);
        step();
        wr_en = '0;
        set_rd(0, 10); set_rd(3, 11);
        push(K_RD, 0, DW'(32'hAAAA));
        push(K_RD, 3, DW'(32'hBBBB));
        step();

        // fill r0..r3
        set_wr(0, 0, DW'(32'h100)); set_wr(1, 1, DW'(32'h101));
        step();
        set_wr(0, 2, DW'(32'h102)); set_wr(1, 3, DW'(32'h103));
        step();
        wr_en = '0;

        // clear_req with a same-cycle write to r3: write dropped, read sees old r3
        clear_req = 1'b1;
        set_wr(0, 3, DW'(32'hDEAD));
        set_rd(0, 3);
        push(K_RD, 0, DW'(32'h103));
        push(K_RDY, 0, '0);
        push(K_CONF, 0, '0);
        step();
        clear_req = 1'b0;
        wr_en = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = '0;
            clear_req = (i == 50);
            if (i == 20) begin
                set_wr(0, 4, DW'(32'h44));
                set_wr(1, 4, DW'(32'h45));
                push(K_CONF, 0, '0);
            end
            if (i == 30) push(K_RD, 0, '0);
            push(K_RDY, 0, DW'(i == DEPTH));
            step();
        end
        clear_req = 1'b0;
        wr_en = '0;
        for (int r = 0; r < 5; r++) begin
            set_rd(r, r);
            push(K_RD, r, '0);
        end
        step();

        // reset 40 cycles into a clear
        clear_req = 1'b1;
        push(K_RDY, 0, '0);
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 39; i++) step();
        reset = 1'b1;
        push(K_RD, 0, '0);
        push(K_RDY, 0, '0);
        step();
        step();
        reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = '0;
            if (i == 60) set_wr(0, 20, '1);
            push(K_RDY, 0, DW'(i == DEPTH));
            step();
        end
        wr_en = '0;
        set_rd(0, 20);
        push(K_RD, 0, '0);
        // first write accepted as soon as ready is high
        set_wr(1, 21, DW'(32'h77));
        step();
        wr_en = '0;
        set_rd(4, 21);
        push(K_RD, 4, DW'(32'h77));
        step();

        step(); step();
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
